// File: rtl/mem_responder.sv
// mem_responder
//   Single-port memory target on the responder side of the valid/ready
//   memory interface. Every request cycle is acknowledged with a one-cycle
//   registered `ready` on the following cycle, so requests can stream at one
//   per clock. Locations that have never been written read back as zero.
//   Out-of-range requests are flagged with `err` and have no side effects.
//
// Ports
//   clk       : clock, all state updates on posedge
//   rst       : asynchronous active-low reset
//   valid     : request present this cycle
//   wr_rd     : 1 = write, 0 = read (qualified by valid)
//   addr      : request address (qualified by valid)
//   wdata     : write data (qualified by valid && wr_rd)
//   ready     : registered acknowledge, one cycle after each request
//   rdata     : registered read data, non-zero only after an in-range read
//   err       : registered, high with ready when addr >= DEPTH
//   wr_count  : accepted in-range writes, wrapping
//   rd_count  : accepted in-range reads, wrapping
module mem_responder #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid,
   input  logic                  wr_rd,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   output logic                  ready,
   output logic [WIDTH-1:0]      rdata,
   output logic                  err,
   output logic [CNT_WIDTH-1:0]  wr_count,
   output logic [CNT_WIDTH-1:0]  rd_count
);

   // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

   logic [WIDTH-1:0]     r_mem [DEPTH];
   logic [DEPTH-1:0]     r_written;
   logic                 r_ready;
   logic [WIDTH-1:0]     r_rdata;
   logic                 r_err;
   logic [CNT_WIDTH-1:0] r_wr_count;
   logic [CNT_WIDTH-1:0] r_rd_count;

   logic w_in_range;
   logic w_wr_en;
   logic w_rd_en;

   assign w_in_range = ({1'b0, addr} < LP_DEPTH);
   assign w_wr_en    = valid &  wr_rd & w_in_range;
   assign w_rd_en    = valid & ~wr_rd & w_in_range;

   // Storage carries no reset; the written flags mask stale contents.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_written <= '0;
      end else if (w_wr_en) begin
         r_written[addr] <= 1'b1;
      end
   end

   // Response stage. A read samples the flag/data as they stand before this
   // edge, so a same-edge write is not visible to it (write-after-read
   // returns old data), while a write on the previous edge is.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ready    <= 1'b0;
         r_rdata    <= '0;
         r_err      <= 1'b0;
         r_wr_count <= '0;
         r_rd_count <= '0;
      end else begin
         r_ready <= valid;
         r_err   <= valid & ~w_in_range;
         r_rdata <= '0;
         if (w_rd_en) begin
            r_rdata    <= r_written[addr] ? r_mem[addr] : '0;
            r_rd_count <= r_rd_count + CNT_WIDTH'(1);
         end
         if (w_wr_en) begin
            r_wr_count <= r_wr_count + CNT_WIDTH'(1);
         end
      end
   end

   assign ready    = r_ready;
   assign rdata    = r_rdata;
   assign err      = r_err;
   assign wr_count = r_wr_count;
   assign rd_count = r_rd_count;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder. Two instances share one stimulus stream:
//   index 0: default parameters (DEPTH=16, CNT_WIDTH=16)
//   index 1: DEPTH=12, CNT_WIDTH=4 (out-of-range and counter wrap cases)
module tb_mem_responder;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       valid = 1'b0;
   logic       wr_rd = 1'b0;
   logic [3:0] addr  = '0;
   logic [7:0] wdata = '0;

   logic        ready0, err0;
   logic [7:0]  rdata0;
   logic [15:0] wc0, rc0;
   logic        ready1, err1;
   logic [7:0]  rdata1;
   logic [3:0]  wc1, rc1;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   mem_responder u_big (
      .clk(clk), .rst(rst), .valid(valid), .wr_rd(wr_rd), .addr(addr),
      .wdata(wdata), .ready(ready0), .rdata(rdata0), .err(err0),
      .wr_count(wc0), .rd_count(rc0)
   );

   mem_responder #(.WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .CNT_WIDTH(4)) u_small (
      .clk(clk), .rst(rst), .valid(valid), .wr_rd(wr_rd), .addr(addr),
      .wdata(wdata), .ready(ready1), .rdata(rdata1), .err(err1),
      .wr_count(wc1), .rd_count(rc1)
   );

   // Reference model: what each instance must show after the current edge.
   int          DEP [2] = '{16, 12};
   int unsigned MSK [2] = '{32'hFFFF, 32'hF};
   logic [7:0]  m_mem [2][16];
   bit          m_wrt [2][16];
   int unsigned m_wc [2];
   int unsigned m_rc [2];
   bit          e_ready [2];
   bit          e_err [2];
   logic [7:0]  e_rdata [2];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 16; j++) m_wrt[k][j] = 1'b0;
            m_wc[k] = 0; m_rc[k] = 0;
            e_ready[k] = 1'b0; e_err[k] = 1'b0; e_rdata[k] = 8'h00;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            e_ready[k] = valid;
            e_err[k]   = 1'b0;
            e_rdata[k] = 8'h00;
            if (valid) begin
               if (int'(addr) >= DEP[k]) begin
                  e_err[k] = 1'b1;
               end else if (wr_rd) begin
                  m_mem[k][addr] = wdata;
                  m_wrt[k][addr] = 1'b1;
                  m_wc[k] = (m_wc[k] + 1) & MSK[k];
               end else begin
                  e_rdata[k] = m_wrt[k][addr] ? m_mem[k][addr] : 8'h00;
                  m_rc[k] = (m_rc[k] + 1) & MSK[k];
               end
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("big.ready",    32'(ready0), 32'(e_ready[0]));
         check("big.err",      32'(err0),   32'(e_err[0]));
         check("big.rdata",    32'(rdata0), 32'(e_rdata[0]));
         check("big.wr_count", 32'(wc0),    m_wc[0]);
         check("big.rd_count", 32'(rc0),    m_rc[0]);
         check("sml.ready",    32'(ready1), 32'(e_ready[1]));
         check("sml.err",      32'(err1),   32'(e_err[1]));
         check("sml.rdata",    32'(rdata1), 32'(e_rdata[1]));
         check("sml.wr_count", 32'(wc1),    m_wc[1]);
         check("sml.rd_count", 32'(rc1),    m_rc[1]);
      end
   end

   // Presents one request; returns at posedge+1 with its response visible.
   task automatic drive(input logic v, input logic w, input logic [3:0] a, input logic [7:0] d);
      valid = v; wr_rd = w; addr = a; wdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      valid = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   int          run;
   logic [3:0]  av;
   logic [7:0]  ev;
   logic [3:0]  sv_wc, sv_rc;

   initial begin
      #1 rst = 1'b0;
      chk_en = 1'b1;
      #1;
      check("reset.ready", 32'(ready0), 32'h0);
      check("reset.wr_count", 32'(wc0), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Write then read same address on consecutive cycles.
      drive(1'b1, 1'b1, 4'd2, 8'hA5);
      check("wr.ready", 32'(ready0), 32'h1);
      check("wr.rdata", 32'(rdata0), 32'h00);
      drive(1'b1, 1'b0, 4'd2, 8'h00);
      check("rd.ready", 32'(ready0), 32'h1);
      check("rd.rdata", 32'(rdata0), 32'hA5);
      check("rd.wr_count", 32'(wc0), 32'h1);
      check("rd.rd_count", 32'(rc0), 32'h1);

      // Unwritten location.
      drive(1'b1, 1'b0, 4'd7, 8'h00);
      check("unwr.ready", 32'(ready0), 32'h1);
      check("unwr.rdata", 32'(rdata0), 32'h00);
      check("unwr.err",   32'(err0),   32'h0);
      drive(1'b0, 1'b0, 4'd0, 8'h00);
      check("idle.ready", 32'(ready0), 32'h0);

      // Asynchronous reset in the middle of a request stream.
      drive(1'b1, 1'b1, 4'd3, 8'h77);
      valid = 1'b1; wr_rd = 1'b0; addr = 4'd3;
      #2 rst = 1'b0;
      #1;
      check("arst.ready",    32'(ready0), 32'h0);
      check("arst.rdata",    32'(rdata0), 32'h0);
      check("arst.err",      32'(err0),   32'h0);
      check("arst.wr_count", 32'(wc0),    32'h0);
      check("arst.rd_count", 32'(rc0),    32'h0);
      check("arst.s_ready",  32'(ready1), 32'h0);
      check("arst.s_wc",     32'(wc1),    32'h0);
      @(posedge clk);
      #1;
      check("arst.discard", 32'(ready0), 32'h0);
      valid = 1'b0;
      rst = 1'b1;
      drive(1'b1, 1'b0, 4'd3, 8'h00);
      check("post.ready", 32'(ready0), 32'h1);
      check("post.rdata", 32'(rdata0), 32'h00);
      drive(1'b0, 1'b0, 4'd0, 8'h00);

      // Streaming: 16 writes then 16 reads, back to back.
      run = 0;
      check("stream.pre", 32'(ready0), 32'h0);
      for (int i = 0; i < 16; i++) begin
         av = 4'(i);
         drive(1'b1, 1'b1, av, 8'(i) ^ 8'h3C);
         if (ready0) run++;
      end
      for (int i = 0; i < 16; i++) begin
         av = 4'(i);
         drive(1'b1, 1'b0, av, 8'h00);
         if (ready0) run++;
         ev = 8'(i) ^ 8'h3C;
         check("stream.rdata", 32'(rdata0), 32'(ev));
      end
      drive(1'b0, 1'b0, 4'd0, 8'h00);
      check("stream.run", run, 32);
      check("stream.end", 32'(ready0), 32'h0);

      // Out of range on the 12-entry instance.
      sv_wc = wc1; sv_rc = rc1;
      drive(1'b1, 1'b1, 4'd13, 8'hFF);
      check("oor.w.ready", 32'(ready1), 32'h1);
      check("oor.w.err",   32'(err1),   32'h1);
      check("oor.w.rdata", 32'(rdata1), 32'h0);
      drive(1'b1, 1'b0, 4'd13, 8'h00);
      check("oor.r.ready", 32'(ready1), 32'h1);
      check("oor.r.err",   32'(err1),   32'h1);
      check("oor.r.rdata", 32'(rdata1), 32'h0);
      check("oor.wc", 32'(wc1), 32'(sv_wc));
      check("oor.rc", 32'(rc1), 32'(sv_rc));
      drive(1'b0, 1'b0, 4'd0, 8'h00);
      check("oor.idle.err", 32'(err1), 32'h0);

      // Counter wrap on the 4-bit counter instance.
      do_reset();
      for (int i = 1; i <= 17; i++) begin
         av = 4'(i % 12);
         drive(1'b1, 1'b1, av, 8'(i));
         if (i == 15) check("wrap.15", 32'(wc1), 32'd15);
         if (i == 16) check("wrap.16", 32'(wc1), 32'd0);
         if (i == 17) check("wrap.17", 32'(wc1), 32'd1);
      end
      drive(1'b0, 1'b0, 4'd0, 8'h00);
      check("wrap.big", 32'(wc0), 32'd17);

      repeat (2) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
